// File: rtl/debounce_toggle_bank.sv
// ---------------------------------------------------------------------------
// debounce_toggle_bank
//
// Multi-channel push-button conditioner. Each channel synchronises a raw
// switch level, debounces it with a restartable counter, and emits registered
// press / release / long-press pulses plus an LED drive that either toggles on
// release (toggle mode) or follows the debounced level (momentary mode).
// Channels are fully independent.
//
// Ports
//   i_Clk      in   1       system clock, rising edge
//   i_Rst_L    in   1       asynchronous active-low reset
//   i_Switch   in   NUM_CH  raw switch levels (async), 1 = pressed
//   i_Mode     in   NUM_CH  per-channel mode, 0 = toggle, 1 = momentary
//   o_Switch   out  NUM_CH  debounced switch level
//   o_Press    out  NUM_CH  one-cycle pulse on debounced 0->1
//   o_Release  out  NUM_CH  one-cycle pulse on debounced 1->0
//   o_Long     out  NUM_CH  one-cycle pulse when a press reaches HOLD_LIMIT
//   o_LED      out  NUM_CH  LED drive
// ---------------------------------------------------------------------------
module debounce_toggle_bank #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Mode,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Long,
  output logic [NUM_CH-1:0] o_LED
);

  localparam int DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

  // Terminal counts: the acceptance / long-press decision is taken while the
  // counter still holds LIMIT-1, so the event lands exactly LIMIT edges later.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic              sync1_r;
      logic              sync2_r;
      logic              stable_r;
      logic [DB_W-1:0]   db_cnt_r;
      logic [HOLD_W-1:0] hold_cnt_r;
      logic              long_fired_r;
      logic              press_r;
      logic              release_r;
      logic              long_r;
      logic              led_r;
      logic              accept_s;
      logic              press_now_s;
      logic              release_now_s;
      logic              fire_s;

      // Edge decode: the stable level changes on this edge when the synced
      // level has differed for the full debounce window.
      always_comb begin
        accept_s      = 1'b0;
        press_now_s   = 1'b0;
        release_now_s = 1'b0;
        fire_s        = 1'b0;
        if ((sync2_r != stable_r) && (db_cnt_r == DB_LAST)) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
        press_now_s   = accept_s & sync2_r;
        release_now_s = accept_s & ~sync2_r;
        // A release landing on the same edge as the hold limit wins: the
        // press did not stay held throughout, so no long press is reported.
        if (stable_r && !long_fired_r && !release_now_s && (hold_cnt_r == HOLD_LAST)) begin
          fire_s = 1'b1;
        end else begin
          fire_s = 1'b0;
        end
      end

      // Two-flop synchroniser for the asynchronous switch pin.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          sync1_r <= 1'b0;
          sync2_r <= 1'b0;
        end else begin
          sync1_r <= i_Switch[g];
          sync2_r <= sync1_r;
        end
      end

      // Debounce counter and accepted stable level; any return to the
      // stable level restarts the count.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          stable_r <= 1'b0;
          db_cnt_r <= {DB_W{1'b0}};
        end else if (sync2_r == stable_r) begin
          stable_r <= stable_r;
          db_cnt_r <= {DB_W{1'b0}};
        end else if (accept_s) begin
          stable_r <= sync2_r;
          db_cnt_r <= {DB_W{1'b0}};
        end else begin
          stable_r <= stable_r;
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end
      end

      // Hold counter and long-press latch; one long press per press.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          hold_cnt_r   <= {HOLD_W{1'b0}};
          long_fired_r <= 1'b0;
        end else if (press_now_s) begin
          hold_cnt_r   <= {HOLD_W{1'b0}};
          long_fired_r <= 1'b0;
        end else if (fire_s) begin
          hold_cnt_r   <= hold_cnt_r;
          long_fired_r <= 1'b1;
        end else if (stable_r && !long_fired_r && (hold_cnt_r != HOLD_LAST)) begin
          hold_cnt_r   <= hold_cnt_r + HOLD_W'(1);
          long_fired_r <= long_fired_r;
        end else begin
          hold_cnt_r   <= hold_cnt_r;
          long_fired_r <= long_fired_r;
        end
      end

      // Registered event pulses, coincident with the new stable level.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          press_r   <= 1'b0;
          release_r <= 1'b0;
          long_r    <= 1'b0;
        end else begin
          press_r   <= press_now_s;
          release_r <= release_now_s;
          long_r    <= fire_s;
        end
      end

      // LED drive: follows stable in momentary mode; in toggle mode flips on
      // a release that was not consumed by a long press, otherwise holds.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          led_r <= 1'b0;
        end else if (i_Mode[g]) begin
          led_r <= stable_r;
        end else if (release_now_s && !long_fired_r) begin
          led_r <= ~led_r;
        end else begin
          led_r <= led_r;
        end
      end

      assign o_Switch[g]  = stable_r;
      assign o_Press[g]   = press_r;
      assign o_Release[g] = release_r;
      assign o_Long[g]    = long_r;
      assign o_LED[g]     = led_r;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_toggle_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_toggle_bank
//
// Directed bench for debounce_toggle_bank with NUM_CH=2, DEBOUNCE_LIMIT=4,
// HOLD_LIMIT=8. Inputs change 1 ns after a rising edge; outputs are sampled
// at the same point. A level applied after edge e is captured by the
// synchroniser at edge e+1 and reaches o_Switch at edge e+6.
// ---------------------------------------------------------------------------
module tb_debounce_toggle_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw;
  logic [1:0] mode;
  logic [1:0] o_sw;
  logic [1:0] o_press;
  logic [1:0] o_rel;
  logic [1:0] o_long;
  logic [1:0] o_led;

  int tests;
  int fails;
  int press_cnt [2];
  int rel_cnt   [2];
  int long_cnt  [2];
  int both_cnt;

  debounce_toggle_bank #(
    .NUM_CH(2),
    .DEBOUNCE_LIMIT(4),
    .HOLD_LIMIT(8)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Switch(sw),
    .i_Mode(mode),
    .o_Switch(o_sw),
    .o_Press(o_press),
    .o_Release(o_rel),
    .o_Long(o_long),
    .o_LED(o_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: advance past the rising edge, then tally the pulse outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      press_cnt[c] += int'(o_press[c]);
      rel_cnt[c]   += int'(o_rel[c]);
      long_cnt[c]  += int'(o_long[c]);
    end
    if ((o_press & o_rel) != 2'b00) both_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    for (int c = 0; c < 2; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
      long_cnt[c]  = 0;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    both_cnt = 0;
    clr();
    rst_n = 1'b0;
    sw    = 2'b11;
    mode  = 2'b00;

    // Reset held with switches pressed: everything stays 0.
    ticks(3);
    check("rst_outputs", {22'd0, o_sw, o_press, o_rel, o_long, o_led}, 32'd0);

    // Release reset; held switches debounce as a fresh press.
    rst_n = 1'b1;
    clr();
    ticks(5);
    check("rst_sw_before", {30'd0, o_sw}, 32'd0);
    tick();
    check("rst_sw_after", {30'd0, o_sw}, 32'd3);
    check("rst_press", {30'd0, o_press}, 32'd3);
    tick();
    check("rst_press_end", {30'd0, o_press}, 32'd0);
    ticks(6);
    check("rst_long_early", {30'd0, o_long}, 32'd0);
    tick();
    check("rst_long", {30'd0, o_long}, 32'd3);
    tick();
    check("rst_long_end", {30'd0, o_long}, 32'd0);
    check("rst_press_cnt", press_cnt[0] * 16 + press_cnt[1], 32'd17);
    check("rst_long_cnt", long_cnt[0] * 16 + long_cnt[1], 32'd17);

    // Release both after the long press: release pulses, LEDs do not toggle.
    sw = 2'b00;
    ticks(5);
    check("rel_sw_before", {30'd0, o_sw}, 32'd3);
    tick();
    check("rel_sw_after", {30'd0, o_sw}, 32'd0);
    check("rel_pulse", {30'd0, o_rel}, 32'd3);
    check("rel_led_kept", {30'd0, o_led}, 32'd0);

    // Bounce on ch0: short high bursts are rejected, final level accepted.
    clr();
    sw = 2'b01; ticks(2);
    sw = 2'b00; ticks(2);
    sw = 2'b01; ticks(2);
    sw = 2'b00; ticks(2);
    check("bounce_sw_idle", {30'd0, o_sw}, 32'd0);
    check("bounce_no_press", press_cnt[0], 32'd0);
    sw = 2'b01;
    ticks(5);
    check("bounce_sw_before", {30'd0, o_sw}, 32'd0);
    tick();
    check("bounce_sw_after", {30'd0, o_sw}, 32'd1);
    check("bounce_press", {30'd0, o_press}, 32'd1);

    // Short press released: toggle-mode LED flips with the release pulse.
    sw = 2'b00;
    ticks(5);
    check("tog1_led_before", {30'd0, o_led}, 32'd0);
    tick();
    check("tog1_rel", {30'd0, o_rel}, 32'd1);
    check("tog1_led", {30'd0, o_led}, 32'd1);
    sw = 2'b01;
    ticks(6);
    check("tog2_press", {30'd0, o_press}, 32'd1);
    sw = 2'b00;
    ticks(6);
    check("tog2_rel", {30'd0, o_rel}, 32'd1);
    check("tog2_led", {30'd0, o_led}, 32'd0);
    check("tog_press_cnt", press_cnt[0], 32'd2);
    check("tog_no_long", long_cnt[0], 32'd0);

    // Long press on ch0: single o_Long at p+8, release leaves LED alone.
    clr();
    sw = 2'b01;
    ticks(6);
    check("long_press", {30'd0, o_press}, 32'd1);
    ticks(7);
    check("long_early", {30'd0, o_long}, 32'd0);
    tick();
    check("long_pulse", {30'd0, o_long}, 32'd1);
    tick();
    check("long_end", {30'd0, o_long}, 32'd0);
    ticks(5);
    sw = 2'b00;
    ticks(6);
    check("long_rel", {30'd0, o_rel}, 32'd1);
    check("long_led_kept", {30'd0, o_led}, 32'd0);
    check("long_cnt", long_cnt[0], 32'd1);

    // Momentary ch1, then switch to toggle while pressed.
    clr();
    mode = 2'b10;
    sw   = 2'b10;
    ticks(6);
    check("mom_sw", {30'd0, o_sw}, 32'd2);
    check("mom_led_lag", {30'd0, o_led}, 32'd0);
    tick();
    check("mom_led", {30'd0, o_led}, 32'd2);
    mode = 2'b00;
    sw   = 2'b00;
    ticks(5);
    check("mode_led_hold", {30'd0, o_led}, 32'd2);
    tick();
    check("mode_rel", {30'd0, o_rel}, 32'd2);
    check("mode_led_toggle", {30'd0, o_led}, 32'd0);
    check("mode_no_long", long_cnt[1], 32'd0);

    // Asynchronous reset mid-hold on ch0.
    sw = 2'b01;
    ticks(6);
    check("ar_press", {30'd0, o_press}, 32'd1);
    ticks(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_outputs", {22'd0, o_sw, o_press, o_rel, o_long, o_led}, 32'd0);
    tick();
    rst_n = 1'b1;
    clr();
    ticks(5);
    check("ar_sw_before", {30'd0, o_sw}, 32'd0);
    tick();
    check("ar_sw_after", {30'd0, o_sw}, 32'd1);
    ticks(7);
    check("ar_no_long", long_cnt[0], 32'd0);
    tick();
    check("ar_long", {30'd0, o_long}, 32'd1);

    check("press_rel_exclusive", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
